// File: rtl/cache_refill_engine_pkg.sv
// ---------------------------------------------------------------------------
// CACHEStruct
// Shared types and constants for the 2-way set-associative data cache and
// its refill engine.
//
// Contents:
//   ADDR_WIDTH / DATA_WIDTH / BANK_NUM  address width, bank word width, banks
//   GRANU_LEN   byte-offset bits inside one bank word
//   OFFSET_LEN  bank-index bits inside one line
//   OFFSET_END  top bit of the in-line byte offset
//   addr_t, offset_t, data_t            basic cache types
//   refill_state_t, beat_t              refill engine FSM and beat counter
//   line_base()                         clears the in-line offset of an address
// ---------------------------------------------------------------------------
package CACHEStruct;

    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;
    localparam int BANK_NUM   = 4;

    // One bank word is DATA_WIDTH/8 bytes, one line is BANK_NUM bank words.
    localparam int GRANU_LEN  = $clog2(DATA_WIDTH / 8);
    localparam int OFFSET_LEN = $clog2(BANK_NUM);
    localparam int OFFSET_END = GRANU_LEN + OFFSET_LEN - 1;

    typedef logic [ADDR_WIDTH-1:0]          addr_t;
    typedef logic [OFFSET_LEN-1:0]          offset_t;
    typedef logic [BANK_NUM*DATA_WIDTH-1:0] data_t;

    typedef offset_t beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    // Line-aligned base address: every bit at or below OFFSET_END cleared.
    function automatic addr_t line_base(input addr_t addr);
        return addr & ~addr_t'({(OFFSET_END + 1){1'b1}});
    endfunction

endpackage

// File: rtl/cache_refill_engine.sv
// ---------------------------------------------------------------------------
// cache_refill_engine
// Moves whole cache lines between the data cache and the 64-bit memory port.
// A request optionally writes a dirty victim line back (BANK_NUM write beats)
// and optionally reads the missing line (BANK_NUM read beats); the assembled
// line is handed back with a one-cycle response pulse.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only while idle)
//   i_req_wb, i_req_fill    request flags: write back first / read new line
//   i_wb_addr, i_wb_line    victim line address and data
//   i_fill_addr             missing line address
//   o_resp_valid            one-cycle completion pulse
//   o_resp_data             filled line, valid with o_resp_valid
//   o_mem_req/o_mem_we      beat request, 1 = write beat
//   o_mem_addr/o_mem_wdata  beat address and write data
//   i_mem_ack/i_mem_rdata   beat accepted, read data valid on ack
// ---------------------------------------------------------------------------
module cache_refill_engine
    import CACHEStruct::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,

    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_wb,
    input  logic                 i_req_fill,
    input  addr_t                i_wb_addr,
    input  data_t                i_wb_line,
    input  addr_t                i_fill_addr,

    output logic                 o_resp_valid,
    output data_t                o_resp_data,

    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output addr_t                o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                 i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    refill_state_t r_state;
    refill_state_t w_nextState;

    beat_t r_beat;

    logic  r_doFill;
    addr_t r_wbBase;
    addr_t r_fillBase;
    data_t r_wbLine;
    data_t r_fillBuf;

    logic  w_accept;
    logic  w_beatDone;
    logic  w_lastBeat;
    addr_t w_beatOffset;

    assign w_accept     = i_req_valid && o_req_ready;
    assign w_beatDone   = o_mem_req && i_mem_ack;
    assign w_lastBeat   = (r_beat == beat_t'(BANK_NUM - 1));
    assign w_beatOffset = addr_t'({r_beat, {GRANU_LEN{1'b0}}});

    assign o_resp_data  = r_fillBuf;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state plus all memory/handshake outputs. The memory outputs depend
    // only on registered state, so req_valid never reaches mem_* in the same
    // cycle and the beat stays stable until it is acked.
    always_comb begin
        w_nextState  = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;

        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (w_accept) begin
                    if (i_req_wb) begin
                        w_nextState = WB;
                    end else if (i_req_fill) begin
                        w_nextState = FILL;
                    end else begin
                        w_nextState = DONE;
                    end
                end
            end
            WB: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = r_wbBase | w_beatOffset;
                o_mem_wdata = r_wbLine[r_beat*DATA_WIDTH +: DATA_WIDTH];
                if (w_beatDone && w_lastBeat) begin
                    w_nextState = r_doFill ? FILL : DONE;
                end
            end
            FILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_fillBase | w_beatOffset;
                if (w_beatDone && w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_resp_valid = 1'b1;
                w_nextState  = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Beat counter: restarts at zero whenever the state changes, so the write
    // phase hands over to the read phase at beat 0 without an idle cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat <= '0;
        end else if (w_nextState != r_state) begin
            r_beat <= '0;
        end else if (w_beatDone && !w_lastBeat) begin
            r_beat <= r_beat + beat_t'(1);
        end
    end

    // Request capture. Only the fill flag needs to outlive acceptance; the
    // writeback flag is consumed by the IDLE transition itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_doFill   <= 1'b0;
            r_wbBase   <= '0;
            r_fillBase <= '0;
            r_wbLine   <= '0;
        end else if (w_accept) begin
            r_doFill   <= i_req_fill;
            r_wbBase   <= line_base(i_wb_addr);
            r_fillBase <= line_base(i_fill_addr);
            r_wbLine   <= i_wb_line;
        end
    end

    // Fill buffer: each acked read beat lands in its own bank slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fillBuf <= '0;
        end else if (r_state == FILL && i_mem_ack) begin
            r_fillBuf[r_beat*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_refill_engine.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_engine
// Directed bench for cache_refill_engine: a behavioural memory answers beats
// (optionally with random wait cycles), a monitor logs every acked beat and
// watches handshake stability, and one initial block walks through the
// directed scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cache_refill_engine;
    import CACHEStruct::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         reqValid = 1'b0;
    logic         reqReady;
    logic         reqWb = 1'b0;
    logic         reqFill = 1'b0;
    logic [63:0]  wbAddr = '0;
    logic [255:0] wbLine = '0;
    logic [63:0]  fillAddr = '0;
    logic         respValid;
    logic [255:0] respData;
    logic         memReq;
    logic         memWe;
    logic [63:0]  memAddr;
    logic [63:0]  memWdata;
    logic         memAck = 1'b0;
    logic [63:0]  memRdata = '0;

    int testsRun = 0;
    int testsFailed = 0;

    // Memory model controls.
    bit           randomWaits = 1'b0;
    bit           addrTag = 1'b0;
    logic [63:0]  rdBase = '0;
    int           waitLeft = -1;

    // Beat log and stability monitor state.
    logic         logWe   [64];
    logic [63:0]  logAddr [64];
    logic [63:0]  logData [64];
    int           logCount = 0;
    int           stabErrors = 0;
    bit           pending = 1'b0;
    logic         pWe;
    logic [63:0]  pAddr;
    logic [63:0]  pData;

    logic [255:0] lastResp;

    cache_refill_engine dut (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_req_valid (reqValid),
        .o_req_ready (reqReady),
        .i_req_wb    (reqWb),
        .i_req_fill  (reqFill),
        .i_wb_addr   (wbAddr),
        .i_wb_line   (wbLine),
        .i_fill_addr (fillAddr),
        .o_resp_valid(respValid),
        .o_resp_data (respData),
        .o_mem_req   (memReq),
        .o_mem_we    (memWe),
        .o_mem_addr  (memAddr),
        .o_mem_wdata (memWdata),
        .i_mem_ack   (memAck),
        .i_mem_rdata (memRdata)
    );

    always #5 clock = ~clock;

    // Memory responder: decides each cycle's ack after the DUT has updated.
    always @(posedge clock) begin
        #1;
        if (!memReq) begin
            memAck   = 1'b0;
            waitLeft = -1;
        end else begin
            if (waitLeft < 0) begin
                waitLeft = randomWaits ? int'($urandom_range(0, 3)) : 0;
            end
            if (waitLeft == 0) begin
                memAck   = 1'b1;
                waitLeft = -1;
            end else begin
                memAck   = 1'b0;
                waitLeft = waitLeft - 1;
            end
        end
        memRdata = rdBase + {62'd0, memAddr[4:3]} + (addrTag ? (memAddr << 16) : 64'd0);
    end

    // Beat logger and handshake stability monitor, mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (pending && (!memReq || memWe !== pWe || memAddr !== pAddr || memWdata !== pData)) begin
                stabErrors = stabErrors + 1;
            end
            pending = memReq && !memAck;
            pWe     = memWe;
            pAddr   = memAddr;
            pData   = memWdata;
            if (memReq && memAck && logCount < 64) begin
                logWe[logCount]   = memWe;
                logAddr[logCount] = memAddr;
                logData[logCount] = memWdata;
                logCount = logCount + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        testsRun = testsRun + 1;
        assert (observed === expected) else begin
            testsFailed = testsFailed + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected line when the memory model returns rdBase + bank (+ tagged address).
    function automatic logic [255:0] expLine(input logic [63:0] base, input logic [63:0] rb, input bit tag);
        logic [255:0] l;
        for (int i = 0; i < 4; i++) begin
            l[i*64 +: 64] = rb + 64'(i) + (tag ? ((base + 64'(8 * i)) << 16) : 64'd0);
        end
        return l;
    endfunction

    // Issue one request, then count cycles from acceptance to resp_valid.
    task automatic applyStimulus(input bit wb, input bit fill, input logic [63:0] wa,
                                 input logic [255:0] wl, input logic [63:0] fa,
                                 output int lat, output logic firstReq);
        int guard = 0;
        while (!reqReady && guard < 50) begin
            tick();
            guard++;
        end
        logCount = 0;
        reqWb    = wb;
        reqFill  = fill;
        wbAddr   = wa;
        wbLine   = wl;
        fillAddr = fa;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        firstReq = memReq;
        lat = 1;
        while (!respValid && lat < 100) begin
            tick();
            lat++;
        end
        lastResp = respData;
    endtask

    initial begin
        int          lat;
        logic        firstReq;
        int          reads;
        int          accepts;
        int          respCnt;
        logic [63:0] b2bAddr [3];
        logic [255:0] b2bResp [4];

        // Reset state.
        tick();
        tick();
        checkOutput("rst_ready", 256'(reqReady), 256'(1));
        checkOutput("rst_mem_req", 256'(memReq), 256'(0));
        checkOutput("rst_mem_we", 256'(memWe), 256'(0));
        checkOutput("rst_mem_addr", 256'(memAddr), 256'(0));
        checkOutput("rst_mem_wdata", 256'(memWdata), 256'(0));
        checkOutput("rst_resp_valid", 256'(respValid), 256'(0));
        checkOutput("rst_resp_data", respData, 256'(0));
        reset = 1'b0;
        tick();

        // Fill only, ack always high.
        rdBase = 64'hA0;
        applyStimulus(1'b0, 1'b1, 64'h0, 256'h0, 64'h1234, lat, firstReq);
        checkOutput("fill_first_req", 256'(firstReq), 256'(1));
        checkOutput("fill_latency", 256'(lat), 256'(5));
        checkOutput("fill_data", lastResp, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        checkOutput("fill_beats", 256'(logCount), 256'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fill_addr%0d", i), 256'(logAddr[i]), 256'(64'h1220 + 64'(8 * i)));
            checkOutput($sformatf("fill_we%0d", i), 256'(logWe[i]), 256'(0));
        end
        tick();
        checkOutput("fill_pulse_end", 256'(respValid), 256'(0));
        checkOutput("fill_ready_back", 256'(reqReady), 256'(1));

        // Writeback + fill, ack always high.
        rdBase = 64'hB0;
        applyStimulus(1'b1, 1'b1, 64'h8000, {64'h44, 64'h33, 64'h22, 64'h11}, 64'h4000, lat, firstReq);
        checkOutput("wbf_latency", 256'(lat), 256'(9));
        checkOutput("wbf_data", lastResp, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
        checkOutput("wbf_beats", 256'(logCount), 256'(8));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wbf_waddr%0d", i), 256'(logAddr[i]), 256'(64'h8000 + 64'(8 * i)));
            checkOutput($sformatf("wbf_wdata%0d", i), 256'(logData[i]), 256'(64'h11 * 64'(i + 1)));
            checkOutput($sformatf("wbf_we%0d", i), 256'(logWe[i]), 256'(1));
            checkOutput($sformatf("wbf_raddr%0d", i), 256'(logAddr[i+4]), 256'(64'h4000 + 64'(8 * i)));
            checkOutput($sformatf("wbf_re%0d", i), 256'(logWe[i+4]), 256'(0));
        end

        // Writeback + fill with random wait cycles.
        tick();
        randomWaits = 1'b1;
        rdBase = 64'hC0;
        stabErrors = 0;
        applyStimulus(1'b1, 1'b1, 64'h2040,
                      {64'hDEAD_0004, 64'hDEAD_0003, 64'hDEAD_0002, 64'hDEAD_0001},
                      64'h3008, lat, firstReq);
        checkOutput("rnd_done", 256'(respValid), 256'(1));
        checkOutput("rnd_data", lastResp, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
        checkOutput("rnd_stable", 256'(stabErrors), 256'(0));
        checkOutput("rnd_beats", 256'(logCount), 256'(8));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rnd_waddr%0d", i), 256'(logAddr[i]), 256'(64'h2040 + 64'(8 * i)));
            checkOutput($sformatf("rnd_wdata%0d", i), 256'(logData[i]), 256'(64'hDEAD_0001 + 64'(i)));
            checkOutput($sformatf("rnd_raddr%0d", i), 256'(logAddr[i+4]), 256'(64'h3000 + 64'(8 * i)));
        end
        randomWaits = 1'b0;

        // Writeback only.
        tick();
        applyStimulus(1'b1, 1'b0, 64'h9010, {64'h4, 64'h3, 64'h2, 64'h1}, 64'h0, lat, firstReq);
        checkOutput("wbo_latency", 256'(lat), 256'(5));
        checkOutput("wbo_beats", 256'(logCount), 256'(4));
        reads = 0;
        for (int i = 0; i < logCount; i++) begin
            if (!logWe[i]) reads++;
        end
        checkOutput("wbo_reads", 256'(reads), 256'(0));
        checkOutput("wbo_addr3", 256'(logAddr[3]), 256'(64'h9018));
        checkOutput("wbo_data3", 256'(logData[3]), 256'(64'h4));

        // No-op request.
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 256'h0, 64'h0, lat, firstReq);
        checkOutput("noop_latency", 256'(lat), 256'(1));
        checkOutput("noop_beats", 256'(logCount), 256'(0));

        // Reset during FILL beat 2.
        tick();
        rdBase = 64'h50;
        reqFill = 1'b1;
        reqWb = 1'b0;
        fillAddr = 64'h5000;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        tick();
        tick();
        checkOutput("rst_mid_req", 256'(memReq), 256'(1));
        checkOutput("rst_mid_addr", 256'(memAddr), 256'(64'h5010));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_after_req", 256'(memReq), 256'(0));
        checkOutput("rst_after_ready", 256'(reqReady), 256'(1));
        checkOutput("rst_after_resp", 256'(respValid), 256'(0));
        tick();
        checkOutput("rst_after_resp2", 256'(respValid), 256'(0));
        rdBase = 64'hD0;
        applyStimulus(1'b0, 1'b1, 64'h0, 256'h0, 64'h6000, lat, firstReq);
        checkOutput("rst_next_latency", 256'(lat), 256'(5));
        checkOutput("rst_next_data", lastResp, {64'hD3, 64'hD2, 64'hD1, 64'hD0});

        // Back-to-back fills with req_valid held high.
        tick();
        addrTag = 1'b1;
        rdBase = 64'h0;
        b2bAddr[0] = 64'h7000;
        b2bAddr[1] = 64'h7100;
        b2bAddr[2] = 64'h7220;
        accepts = 0;
        respCnt = 0;
        reqWb = 1'b0;
        reqFill = 1'b1;
        fillAddr = b2bAddr[0];
        reqValid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bit acc;
            acc = reqReady && reqValid;
            tick();
            if (acc) begin
                accepts++;
                if (accepts < 3) fillAddr = b2bAddr[accepts];
                else reqValid = 1'b0;
            end
            if (respValid) begin
                if (respCnt < 4) b2bResp[respCnt] = respData;
                respCnt++;
            end
        end
        checkOutput("b2b_accepts", 256'(accepts), 256'(3));
        checkOutput("b2b_resps", 256'(respCnt), 256'(3));
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("b2b_data%0d", i), b2bResp[i], expLine(b2bAddr[i], 64'h0, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
